cdc_hs_src: RTL and testbench

Source-domain end of a four-phase req/ack CDC handshake in the AXI4-Lite to APB bridge.
- Accepts a data word on a local valid/ready interface and launches it across the clock boundary on a held-stable data bus qualified by req_async.
- Waits for the destination's ack, which arrives asynchronously and is synchronized internally with a 2-flop synchronizer.
- Pairs with a destination-side receiver that samples the data bus through its own 2-flop synchronizer on req.

---
 rtl/cdc_hs_pkg.sv | 15 +
 rtl/sync_2ff.sv | 39 +++
 rtl/cdc_hs_src.sv | 147 ++++++++++++++
 tb/tb_cdc_hs_src.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_hs_pkg.sv
// Shared types for the four-phase req/ack CDC handshake source.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cdc_hs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        REL  = 2'b10
    } hs_state_e;

    // Depth of the ack synchronizer chain.
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sync_2ff.sv
// Multi-flop level synchronizer for signals crossing into clk.
// Latency: SYNC_STAGES clk cycles from d to q.
// Backpressure: none; a plain level is resampled every cycle.
//
// Ports:
//   clk    destination clock
//   rst_n  asynchronous active-low reset; clears every stage
//   d      asynchronous input level
//   q      synchronized level
module sync_2ff
    import cdc_hs_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_d;

    // Stage 0 samples the raw input; each later stage resamples its predecessor.
    always_comb begin
        stage_d = {stage_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_hs_src.sv
// Source end of a four-phase req/ack CDC handshake: launches one word per req.
// Latency: req one cycle after accept; ack seen 2 cycles after ack_async moves.
// Backpressure: in_ready only in IDLE, so one word per full handshake round trip.
//
// Ports:
//   clk, rst_n            source clock, asynchronous active-low reset
//   in_valid/in_ready     upstream handshake, in_data is the word
//   req_async/data_async  request and held-stable word towards the destination
//   ack_async             destination ack, asynchronous to clk
//   hs_done               one-cycle pulse on the first IDLE cycle after ack drops
//   busy                  high whenever a handshake is in flight
//   err_timeout/err_clr   sticky REQ timeout flag and its clear
//
// Optional feature macro: CDC_HS_TIMEOUT_EN builds the REQ timeout counter;
// without it err_timeout is tied low and err_clr is ignored.
module cdc_hs_src
    import cdc_hs_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              req_async,
    output logic [DATA_W-1:0] data_async,
    input  logic              ack_async,
    output logic              hs_done,
    output logic              busy,
    output logic              err_timeout,
    input  logic              err_clr
);

    hs_state_e         state_q, state_d;
    logic              req_q, req_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_q, done_d;
    logic              ack_s;

    sync_2ff #(.WIDTH(1)) u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ack_async),
        .q     (ack_s)
    );

    // A stale ack_s seen in IDLE is deliberately ignored: REQ simply waits for
    // it and REL waits for it to drop, so no word is lost or duplicated.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = REL;
                end
            end
            REL: begin
                if (!ack_s) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    // Nothing can be captured while reset is held, so ready is withheld then.
    assign in_ready   = rst_n && (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign req_async  = req_q;
    assign data_async = data_q;
    assign hs_done    = done_q;

`ifdef CDC_HS_TIMEOUT_EN
    localparam int                CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0]  CNT_SET = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // The flag is set only on the increment that reaches TIMEOUT_CYC, so a clear
    // while still stuck in REQ (counter saturated) is not immediately undone.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (state_q == IDLE && in_valid) begin
            cnt_d = '0;
        end else if (state_q == REQ && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (state_q == REQ && cnt_q == CNT_SET) begin
            err_d = 1'b1;
        end
        if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_timeout = err_q;
`else
    logic unused_cfg;
    assign unused_cfg  = err_clr ^ (TIMEOUT_CYC >= 2);
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_hs_src.sv
module tb_cdc_hs_src;

    localparam int DATA_W = 32;
    localparam int TCYC   = 16;
`ifdef CDC_HS_TIMEOUT_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              req_async;
    logic [DATA_W-1:0] data_async;
    logic              ack_async;
    logic              hs_done;
    logic              busy;
    logic              err_timeout;
    logic              err_clr;

    cdc_hs_src #(.DATA_W(DATA_W), .TIMEOUT_CYC(TCYC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .req_async   (req_async),
        .data_async  (data_async),
        .ack_async   (ack_async),
        .hs_done     (hs_done),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [DATA_W-1:0] exp_q[$];
    int rises = 0, done_cnt = 0, unstable = 0, rdy_viol = 0, done_viol = 0;
    logic auto_ack = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: scoreboard pop on every req rise plus per-cycle protocol tallies.
    initial begin
        logic              req_prev = 1'b0;
        logic              done_prev = 1'b0;
        logic [DATA_W-1:0] held = '0;
        logic [DATA_W-1:0] e;
        forever begin
            @(negedge clk);
            if (req_async && !req_prev) begin
                rises++;
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_req", 64'(data_async), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_data", 64'(data_async), 64'(e));
                end
                held = data_async;
            end else if (req_async && data_async !== held) begin
                unstable++;
            end
            if (rst_n && (in_ready === busy)) rdy_viol++;
            if (hs_done && done_prev) done_viol++;
            if (hs_done) done_cnt++;
            req_prev  = req_async;
            done_prev = hs_done;
        end
    end

    // Destination model: ack 3 cycles after req rise, drop 3 cycles after req fall.
    initial begin
        forever begin
            @(negedge clk);
            if (auto_ack && req_async && !ack_async) begin
                repeat (3) @(posedge clk);
                #2 ack_async = 1'b1;
                for (int n = 0; n < 200 && req_async; n++) @(negedge clk);
                repeat (3) @(posedge clk);
                #2 ack_async = 1'b0;
            end
        end
    end

    task automatic send(input logic [DATA_W-1:0] w);
        int n;
        @(posedge clk); #2;
        in_valid = 1'b1;
        in_data  = w;
        exp_q.push_back(w);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 500);
        if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int start, input string name);
        for (int n = 0; n < 300 && done_cnt == start; n++) @(negedge clk);
        check(name, 64'(done_cnt - start), 64'd1);
    endtask

    initial begin
        int d0, r0, spur;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hCAFE_0001;
        ack_async = 1'b0;
        err_clr   = 1'b0;

        // 1: reset with in_valid held, then accept on the first cycle.
        exp_q.push_back(32'hCAFE_0001);
        repeat (3) @(negedge clk);
        check("rst_req", 64'(req_async), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd0);
        check("rst_err", 64'(err_timeout), 64'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(in_ready), 64'd1);
        check("post_rst_req", 64'(req_async), 64'd0);
        @(posedge clk); #2 in_valid = 1'b0;
        @(negedge clk);
        check("req_after_accept", 64'(req_async), 64'd1);
        check("busy_after_accept", 64'(busy), 64'd1);
        wait_done(0, "t1_done");

        // 2: single transfer, exactly one hs_done pulse.
        d0 = done_cnt;
        send(32'hDEAD_BEEF);
        wait_done(d0, "t2_done");
        repeat (6) @(negedge clk);
        check("t2_one_pulse", 64'(done_cnt - d0), 64'd1);

        // 3: back-to-back with in_valid held; words 2..4 accepted in the hs_done cycle.
        d0 = done_cnt;
        r0 = rises;
        @(posedge clk); #2 in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int n = 0;
            in_data = DATA_W'(i + 1);
            exp_q.push_back(DATA_W'(i + 1));
            do begin
                @(negedge clk);
                n++;
            end while (!in_ready && n < 500);
            if (i > 0) check("b2b_accept_in_done", 64'(hs_done), 64'd1);
            @(posedge clk); #2;
        end
        in_valid = 1'b0;
        wait_done(d0 + 3, "t3_done");
        check("t3_rises", 64'(rises - r0), 64'd4);

        // 4: spurious ack while IDLE is ignored.
        auto_ack = 1'b0;
        d0 = done_cnt;
        spur = 0;
        @(posedge clk); #2 ack_async = 1'b1;
        repeat (5) begin @(negedge clk); if (busy || req_async) spur++; end
        @(posedge clk); #2 ack_async = 1'b0;
        repeat (3) begin @(negedge clk); if (busy || req_async) spur++; end
        check("spur_idle", 64'(spur), 64'd0);
        check("spur_no_done", 64'(done_cnt - d0), 64'd0);
        auto_ack = 1'b1;
        send(32'h0000_0044);
        wait_done(d0, "t4_done");

        // 5: reset while in REQ with ack high.
        auto_ack = 1'b0;
        send(32'h5555_0000);
        @(posedge clk); #2 ack_async = 1'b1;
        @(posedge clk); #2;
        check("pre_rst_busy", 64'(busy), 64'd1);
        check("pre_rst_req", 64'(req_async), 64'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_req", 64'(req_async), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        ack_async = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        auto_ack = 1'b1;
        d0 = done_cnt;
        send(32'h0000_0001);
        wait_done(d0, "t5_done");

        // 6: ack withheld -> timeout flag, clear, late ack completes.
        auto_ack = 1'b0;
        d0 = done_cnt;
        send(32'hA5A5_0006);
        @(negedge clk);
        repeat (TCYC - 1) @(negedge clk);
        check("to_not_yet", 64'(err_timeout), 64'd0);
        @(negedge clk);
        check("to_set", 64'(err_timeout), 64'(EXP_ERR));
        check("to_req_held", 64'(req_async), 64'd1);
        @(posedge clk); #2 err_clr = 1'b1;
        @(posedge clk); #2 err_clr = 1'b0;
        @(negedge clk);
        check("to_cleared", 64'(err_timeout), 64'd0);
        repeat (5) @(negedge clk);
        check("to_stays_clear", 64'(err_timeout), 64'd0);
        @(posedge clk); #2 ack_async = 1'b1;
        for (int n = 0; n < 50 && req_async; n++) @(negedge clk);
        check("late_ack_req_drop", 64'(req_async), 64'd0);
        @(posedge clk); #2 ack_async = 1'b0;
        wait_done(d0, "t6_done");

        repeat (3) @(negedge clk);
        check("sb_empty", 64'(exp_q.size()), 64'd0);
        check("data_stable", 64'(unstable), 64'd0);
        check("ready_vs_busy", 64'(rdy_viol), 64'd0);
        check("done_width", 64'(done_viol), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
